// File: rtl/approx_mul_pkg.sv
// Shared defaults and column-mode helper for the half-adder pairing multiplier.
// Row widths depend on the instance WIDTH, so the row typedefs live in the top.
package approx_mul_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_APPROX_COLS = 4;

    // A doubly-covered column is OR-summed (carry dropped) only in approximate
    // mode and only below the approximation boundary.
    function automatic logic col_is_approx(input int unsigned c,
                                           input logic        exact,
                                           input int unsigned approx_cols);
        return !exact && (c < approx_cols);
    endfunction

endpackage

// File: rtl/approx_ha_pair.sv
// Combinational generator for one row pair (2*PAIR, 2*PAIR+1) of the partial-product array.
// Outputs are relative to absolute column 2*PAIR: t[j] has weight 2^(2*PAIR+j), b[j] has weight 2^(2*PAIR+j+2).
module approx_ha_pair
    import approx_mul_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned PAIR        = 0,
    parameter int unsigned APPROX_COLS = DEF_APPROX_COLS
) (
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_x_lo,
    input  logic             i_x_hi,
    input  logic             i_exact,
    output logic [WIDTH:0]   o_t,
    output logic [WIDTH-2:0] o_b
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_h;

    assign w_a = i_y & {WIDTH{i_x_lo}};
    assign w_h = i_y & {WIDTH{i_x_hi}};

    // Local column j (1..WIDTH-1) holds w_a[j] and w_h[j-1]; its carry lands in o_b[j-1].
    always_comb begin
        o_t        = '0;
        o_b        = '0;
        o_t[0]     = w_a[0];
        o_t[WIDTH] = w_h[WIDTH-1];
        for (int unsigned j = 1; j < WIDTH; j++) begin
            if (col_is_approx(2 * PAIR + j, i_exact, APPROX_COLS)) begin
                o_t[j] = w_a[j] | w_h[j-1];
            end else begin
                o_t[j]   = w_a[j] ^ w_h[j-1];
                o_b[j-1] = w_a[j] & w_h[j-1];
            end
        end
    end

endmodule

// File: rtl/approx_mul_ha_pipe.sv
// Three-stage pipelined WIDTHxWIDTH unsigned approximate multiplier with valid/ready streaming.
// S1 operands, S2 half-adder pair rows, S3 final row sum; all stages advance together.
module approx_mul_ha_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned APPROX_COLS = DEF_APPROX_COLS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_exact
);

    localparam int unsigned NPAIR = WIDTH / 2;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef logic [WIDTH:0]   t_row;
    typedef logic [WIDTH-2:0] b_row;

    logic                  w_adv;

    logic                  r_s1_valid;
    logic [WIDTH-1:0]      r_s1_x;
    logic [WIDTH-1:0]      r_s1_y;
    logic                  r_s1_exact;

    t_row [NPAIR-1:0]      w_t;
    b_row [NPAIR-1:0]      w_b;

    logic                  r_s2_valid;
    t_row [NPAIR-1:0]      r_s2_t;
    b_row [NPAIR-1:0]      r_s2_b;
    logic                  r_s2_exact;

    logic [PW-1:0]         w_sum;

    logic                  r_s3_valid;
    logic [PW-1:0]         r_s3_p;
    logic                  r_s3_exact;

    // Only a stalled, occupied output stage blocks the pipe; bubbles are shifted, not collapsed.
    assign w_adv    = !(r_s3_valid && !out_ready);
    assign in_ready = w_adv;

    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
        approx_ha_pair #(
            .WIDTH       (WIDTH),
            .PAIR        (k),
            .APPROX_COLS (APPROX_COLS)
        ) u_pair (
            .i_y     (r_s1_y),
            .i_x_lo  (r_s1_x[2*k]),
            .i_x_hi  (r_s1_x[2*k+1]),
            .i_exact (r_s1_exact),
            .o_t     (w_t[k]),
            .o_b     (w_b[k])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < NPAIR; k++) begin
            w_sum = w_sum + (PW'(r_s2_t[k]) << (2 * k))
                          + (PW'(r_s2_b[k]) << (2 * k + 2));
        end
    end

    // Data registers load only with a valid beat so out_p holds its last product across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_exact <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_t     <= '0;
            r_s2_b     <= '0;
            r_s2_exact <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_p     <= '0;
            r_s3_exact <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_x     <= in_x;
                r_s1_y     <= in_y;
                r_s1_exact <= in_exact;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_t     <= w_t;
                r_s2_b     <= w_b;
                r_s2_exact <= r_s1_exact;
            end
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_p     <= w_sum;
                r_s3_exact <= r_s2_exact;
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign out_p     = r_s3_p;
    assign out_exact = r_s3_exact;

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Directed and streaming checks for approx_mul_ha_pipe: 8x8 default instance plus a 16x16 exact-only instance.
module tb_approx_mul_ha_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_exact;
    logic [7:0]  a_in_x, a_in_y;
    logic        a_out_valid, a_out_ready, a_out_exact;
    logic [15:0] a_out_p;

    logic        b_in_valid, b_in_ready, b_in_exact;
    logic [15:0] b_in_x, b_in_y;
    logic        b_out_valid, b_out_ready, b_out_exact;
    logic [31:0] b_out_p;

    int n_tests = 0;
    int n_fail  = 0;

    approx_mul_ha_pipe u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_x      (a_in_x),
        .in_y      (a_in_y),
        .in_exact  (a_in_exact),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_p     (a_out_p),
        .out_exact (a_out_exact)
    );

    approx_mul_ha_pipe #(.WIDTH(16), .APPROX_COLS(0)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_x      (b_in_x),
        .in_y      (b_in_y),
        .in_exact  (b_in_exact),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_p     (b_out_p),
        .out_exact (b_out_exact)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated beat on the 8-bit instance, checking the 3-cycle latency and result.
    task automatic send_directed(input string tag, input logic [7:0] x, input logic [7:0] y,
                                 input logic e, input logic [15:0] exp_p);
        @(negedge clk);
        a_in_x     = x;
        a_in_y     = y;
        a_in_exact = e;
        a_in_valid = 1'b1;
        #1 check_eq({tag, "/in_ready"}, a_in_ready, 1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_eq({tag, "/lat1"}, a_out_valid, 0);
        @(negedge clk);
        check_eq({tag, "/lat2"}, a_out_valid, 0);
        @(negedge clk);
        check_eq({tag, "/valid"}, a_out_valid, 1);
        check_eq({tag, "/p"}, a_out_p, exp_p);
        check_eq({tag, "/exact"}, a_out_exact, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];
        logic        exq_q[$];
        logic [7:0]  vx, vy;
        logic        fired, seen;
        int          sent, got;

        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_x      = '0;
        a_in_y      = '0;
        a_in_exact  = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_x      = '0;
        b_in_y      = '0;
        b_in_exact  = 1'b0;
        b_out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("reset/out_valid", a_out_valid, 0);
        check_eq("reset/out_p", a_out_p, 0);
        check_eq("reset/out_exact", a_out_exact, 0);
        check_eq("reset/out_valid16", b_out_valid, 0);
        rst = 1'b0;
        #1 check_eq("reset/in_ready", a_in_ready, 1);

        send_directed("ff_exact",  8'hFF, 8'hFF, 1'b1, 16'hFE01);
        send_directed("ff_approx", 8'hFF, 8'hFF, 1'b0, 16'd65003);
        send_directed("3x3_approx", 8'd3, 8'd3, 1'b0, 16'd7);
        send_directed("3x3_exact",  8'd3, 8'd3, 1'b1, 16'd9);
        send_directed("3x1_approx", 8'd3, 8'd1, 1'b0, 16'd3);
        send_directed("0xab_approx", 8'd0, 8'hAB, 1'b0, 16'd0);
        send_directed("abx0_exact", 8'hAB, 8'd0, 1'b1, 16'd0);
        send_directed("abxcd_exact", 8'hAB, 8'hCD, 1'b1, 16'h88EF);

        // Back-to-back stream with output stalled during cycles 5..7.
        sent  = 0;
        got   = 0;
        fired = 1'b0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if (fired || !a_in_valid) begin
                if (sent < 8) begin
                    vx         = 8'(sent * 37 + 5);
                    vy         = 8'(sent * 53 + 11);
                    a_in_x     = vx;
                    a_in_y     = vy;
                    a_in_exact = 1'b1;
                    a_in_valid = 1'b1;
                end else begin
                    a_in_valid = 1'b0;
                end
            end
            a_out_ready = !(c >= 5 && c <= 7);
            #1;
            if (c >= 4 && c <= 8)
                check_eq("stream/in_ready", a_in_ready, (c >= 5 && c <= 7) ? 0 : 1);
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream/spurious", a_out_valid, 0);
                end else begin
                    check_eq("stream/p", a_out_p, exp_q[0]);
                    check_eq("stream/exact", a_out_exact, 1);
                    if (a_out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            fired = a_in_valid && a_in_ready;
            if (fired) begin
                exp_q.push_back(32'({8'd0, a_in_x} * {8'd0, a_in_y}));
                sent++;
            end
        end
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        check_eq("stream/sent", sent, 8);
        check_eq("stream/retired", got, 8);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | a_out_valid;
        end
        check_eq("stream/no_dup", seen, 0);

        // Reset with two beats in flight.
        @(negedge clk);
        a_in_x = 8'd5; a_in_y = 8'd7; a_in_exact = 1'b1; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_x = 8'd9; a_in_y = 8'd9; a_in_exact = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid/pre_valid", a_out_valid, 1);
        check_eq("rst_mid/pre_p", a_out_p, 35);
        rst = 1'b1;
        #1;
        check_eq("rst_mid/out_valid", a_out_valid, 0);
        check_eq("rst_mid/out_p", a_out_p, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | a_out_valid;
        end
        check_eq("rst_mid/no_output", seen, 0);

        // 16-bit, APPROX_COLS=0: random traffic in both modes must be exact.
        exp_q.delete();
        sent  = 0;
        got   = 0;
        fired = 1'b0;
        for (int c = 0; c < 8000 && got < 1000; c++) begin
            @(negedge clk);
            if (fired || !b_in_valid) begin
                if (sent < 1000 && $urandom_range(0, 4) != 0) begin
                    b_in_x     = 16'($urandom);
                    b_in_y     = 16'($urandom);
                    b_in_exact = 1'($urandom_range(0, 1));
                    b_in_valid = 1'b1;
                end else begin
                    b_in_valid = 1'b0;
                end
            end
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand16/spurious", b_out_valid, 0);
                end else begin
                    check_eq("rand16/p", b_out_p, exp_q.pop_front());
                    check_eq("rand16/exact", b_out_exact, exq_q.pop_front());
                    got++;
                end
            end
            fired = b_in_valid && b_in_ready;
            if (fired) begin
                exp_q.push_back({16'd0, b_in_x} * {16'd0, b_in_y});
                exq_q.push_back(b_in_exact);
                sent++;
            end
        end
        check_eq("rand16/retired", got, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
